// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults, write-arbiter state encoding and clog2 helper
package fifo_pkg;

    // Default FIFO geometry shared by the FIFO top and its write-side front end.
    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Write-arbiter FSM encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotating-priority encoder
//
// Purpose: returns the first asserted request found when scanning upward
// (with wrap) from index 'start'.
// Ports:
//   req    in   NREQ   request vector
//   start  in   IW     index with highest priority this cycle (must be < NREQ)
//   found  out  1      at least one request asserted
//   idx    out  IW     index of the winning request (0 when found=0)
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    int          pos;
    logic [IW-1:0] pos_idx;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(start) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos_idx = IW'(pos);
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter for the FIFO write port
//
// Purpose: shares one FIFO write port among NREQ requesters. The owner may
// write up to MAXBURST words per grant; ownership then rotates. Data and winc
// pass straight through from the owner with no register stage.
// Ports:
//   wclk       in   1            write-domain clock
//   wrst_n     in   1            asynchronous active-low reset
//   req_valid  in   NREQ         requester i presents a word
//   req_data   in   NREQ*DSIZE   requester i word in [i*DSIZE +: DSIZE]
//   req_ready  out  NREQ         one-hot (owner only) or zero
//   wdata      out  DSIZE        to FIFO wdata
//   winc       out  1            to FIFO winc, already gated by wfull
//   wfull      in   1            from FIFO wfull
//   grant_id   out  IW           current owner, valid while busy
//   busy       out  1            a grant is active
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DSIZE    = DSIZE_DEF,
    parameter  int MAXBURST = 4,
    localparam int IW       = clog2(NREQ),
    localparam int BW       = clog2(MAXBURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [DSIZE-1:0]      wdata,
    output logic                  winc,
    input  logic                  wfull,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic             owner_valid;
    logic [IW-1:0]    next_g;
    logic             xfer;
    logic             last_beat;
    logic             release_grant;
    logic [IW-1:0]    pick_start;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DSIZE +: DSIZE];
        end
    end

    // Datapath: everything is selected by the registered owner.
    always_comb begin
        owner_valid = req_valid[grant_id_q];
        busy        = (state_q == GRANT);
        winc        = busy && owner_valid && !wfull;
        xfer        = winc;
        wdata       = data_arr[grant_id_q];
        req_ready   = '0;
        if (busy) begin
            req_ready[grant_id_q] = !wfull;
        end
        grant_id    = grant_id_q;
    end

    always_comb begin
        next_g        = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);
        last_beat     = xfer && (beat_cnt_q == BW'(MAXBURST - 1));
        // An owner that is not valid this cycle gives up the port; a stalled
        // (wfull) owner that is still valid keeps it.
        release_grant = busy && (last_beat || !owner_valid);
        // Scanning from g+1 leaves g last in line, so it only wins again when
        // nobody else is valid; when it dropped valid it cannot win at all.
        pick_start    = busy ? next_g : rr_ptr_q;
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    rr_ptr_d   = next_g;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        grant_id_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
